// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signals of the branch predictor, bundled for the core pipeline.
// master is the pipeline side, slave is the predictor.
interface branch_predictor_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic [31:0]          if_pc;
    logic                 pred_taken;
    logic                 ex_valid;
    logic [31:0]          ex_pc;
    logic                 ex_pred_taken;
    logic                 actual_outcome;
    logic [31:0]          ex_target;
    logic                 stall;
    logic                 mispredict;
    logic [31:0]          redirect_pc;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_pred_taken, actual_outcome, ex_target, stall,
        input  pred_taken, mispredict, redirect_pc, branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_pred_taken, actual_outcome, ex_target, stall,
        output pred_taken, mispredict, redirect_pc, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counter table, registered mispredict/redirect
// with a one-cycle wrong-path shadow, and saturating resolve/mispredict statistics.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);
    localparam int unsigned          Entries = 1 << INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [1:0]            bht_q [Entries];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_next;
    logic                  resolve;
    logic                  mispredict_d;
    logic                  mispredict_q;
    logic                  shadow_q;
    logic [31:0]           redirect_d;
    logic [31:0]           redirect_q;
    logic [CNT_WIDTH-1:0]  bc_d;
    logic [CNT_WIDTH-1:0]  bc_q;
    logic [CNT_WIDTH-1:0]  mc_d;
    logic [CNT_WIDTH-1:0]  mc_q;
    logic                  unused_pc_bits;

    assign rd_idx         = bus.if_pc[INDEX_BITS+1:2];
    assign wr_idx         = bus.ex_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.if_pc[31:INDEX_BITS+2], bus.if_pc[1:0]};

    // Read straight from the registered table, so a same-index update shows next cycle.
    assign bus.pred_taken       = bht_q[rd_idx][1];
    assign bus.mispredict       = mispredict_q;
    assign bus.redirect_pc      = redirect_q;
    assign bus.branch_count     = bc_q;
    assign bus.mispredict_count = mc_q;

    always_comb begin
        // The EX slot during a flush cycle holds a wrong-path instruction.
        resolve = bus.ex_valid & ~bus.stall & ~shadow_q;

        ctr_cur  = bht_q[wr_idx];
        ctr_next = ctr_cur;
        if (bus.actual_outcome) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end

        mispredict_d = resolve & (bus.actual_outcome != bus.ex_pred_taken);

        redirect_d = redirect_q;
        if (mispredict_d) begin
            redirect_d = bus.actual_outcome ? bus.ex_target : bus.ex_pc + 32'd4;
        end

        bc_d = bc_q;
        if (resolve && (bc_q != '1)) bc_d = bc_q + CntOne;

        mc_d = mc_q;
        if (mispredict_d && (mc_q != '1)) mc_d = mc_q + CntOne;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Entries; i++) begin
                bht_q[i] <= 2'b01;
            end
            mispredict_q <= 1'b0;
            shadow_q     <= 1'b0;
            redirect_q   <= 32'd0;
            bc_q         <= '0;
            mc_q         <= '0;
        end else begin
            if (resolve) bht_q[wr_idx] <= ctr_next;
            mispredict_q <= mispredict_d;
            shadow_q     <= mispredict_d;
            redirect_q   <= redirect_d;
            bc_q         <= bc_d;
            mc_q         <= mc_d;
        end
    end
endmodule
